// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants and the hex-to-7-segment lookup for the multiplexed
// seven-segment scan controller.
//   SEG_OFF        all segments dark (active-low)
//   SEG_*_DEF      default digit count, slot length and blank length
//   digit_t        one digit entry {on, data}
//   hex7()         4-bit value -> active-low segments {g..a}
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam int SEG_NDIG_DEF  = 8;
  localparam int SEG_DIV_DEF   = 1000;
  localparam int SEG_BLANK_DEF = 50;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef struct packed {
    logic       on;
    logic [3:0] data;
  } digit_t;

  function automatic logic [6:0] hex7(input logic [3:0] x);
    logic [6:0] y;
    y = SEG_OFF;
    case (x)
      4'h0: y = 7'h40;
      4'h1: y = 7'h79;
      4'h2: y = 7'h24;
      4'h3: y = 7'h30;
      4'h4: y = 7'h19;
      4'h5: y = 7'h12;
      4'h6: y = 7'h02;
      4'h7: y = 7'h78;
      4'h8: y = 7'h00;
      4'h9: y = 7'h10;
      4'hA: y = 7'h08;
      4'hB: y = 7'h03;
      4'hC: y = 7'h46;
      4'hD: y = 7'h21;
      4'hE: y = 7'h06;
      4'hF: y = 7'h0E;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/seg_hex7.sv
// -----------------------------------------------------------------------------
// seg_hex7
// Combinational hex digit decoder, shared by all digits of the scanner.
//   x  in  4  hex value
//   en in  1  1 = decode x, 0 = all segments off
//   y  out 7  active-low segments {g..a}
// -----------------------------------------------------------------------------
module seg_hex7
  import seg_pkg::*;
(
  input  logic [3:0] x,
  input  logic       en,
  output logic [6:0] y
);

  assign y = en ? hex7(x) : SEG_OFF;

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed seven-segment scanner with a double-buffered digit bank.
// Writes land in a shadow bank; a commit copies shadow -> active at the next
// frame end so the visible frame never tears. Each digit slot starts with a
// short all-dark blank interval to suppress ghosting.
//   clk           in          clock, rising edge
//   rst           in          asynchronous reset, active-high
//   wr_valid      in          shadow write strobe
//   wr_idx        in  IDXW    digit index for the write
//   wr_data       in  4       hex value
//   wr_on         in  1       digit visible
//   commit_valid  in  1       request shadow -> active copy
//   commit_ready  out 1       no commit pending
//   commit_done   out 1       one-cycle pulse after the copy takes effect
//   an            out NDIG    digit enables, active-low
//   seg           out 7       segments {g..a}, active-low
// -----------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter  int NDIG  = SEG_NDIG_DEF,
  parameter  int DIV   = SEG_DIV_DEF,
  parameter  int BLANK = SEG_BLANK_DEF,
  localparam int IDXW  = $clog2(NDIG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_valid,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [3:0]      wr_data,
  input  logic            wr_on,
  input  logic            commit_valid,
  output logic            commit_ready,
  output logic            commit_done,
  output logic [NDIG-1:0] an,
  output logic [6:0]      seg
);

  localparam int              CNTW      = $clog2(DIV);
  localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(DIV - 1);
  localparam logic [CNTW-1:0] BLANK_END = CNTW'(BLANK);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NDIG - 1);

  logic [CNTW-1:0] r_cnt;
  logic [IDXW-1:0] r_idx;
  logic            r_pending;
  logic            r_done;
  logic [NDIG-1:0] r_an;
  logic [6:0]      r_seg;
  digit_t          r_shadow [NDIG];
  digit_t          r_active [NDIG];

  logic [CNTW-1:0] w_cnt_nxt;
  logic [IDXW-1:0] w_idx_nxt;
  logic            w_slot_end;
  logic            w_frame_end;
  logic            w_accept;
  logic            w_copy;
  logic            w_blank_nxt;
  digit_t          w_cur_nxt;
  logic [6:0]      w_seg_nxt;
  logic [NDIG-1:0] w_an_nxt;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
  assign w_accept    = commit_valid && !r_pending;
  // pending is sampled before this cycle's accept, so a commit accepted in
  // the frame-end cycle waits for the following frame end
  assign w_copy      = w_frame_end && r_pending;

  assign w_cnt_nxt = w_slot_end ? '0 : r_cnt + CNTW'(1);
  assign w_idx_nxt = !w_slot_end ? r_idx :
                     (r_idx == IDX_LAST) ? '0 : r_idx + IDXW'(1);

  // Outputs are decoded from next-state values and registered, so an/seg
  // describe the same cycle as cnt/idx/active. On a copy edge the digit
  // shown next comes from the shadow bank as it stood before this edge.
  assign w_cur_nxt   = w_copy ? r_shadow[w_idx_nxt] : r_active[w_idx_nxt];
  assign w_blank_nxt = (w_cnt_nxt < BLANK_END);

  seg_hex7 u_hex7 (
    .x  (w_cur_nxt.data),
    .en (w_cur_nxt.on && !w_blank_nxt),
    .y  (w_seg_nxt)
  );

  always_comb begin
    w_an_nxt = '1;
    if (!w_blank_nxt) w_an_nxt[w_idx_nxt] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
      r_an      <= '1;
      r_seg     <= SEG_OFF;
      for (int i = 0; i < NDIG; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_idx  <= w_idx_nxt;
      r_done <= w_copy;
      r_an   <= w_an_nxt;
      r_seg  <= w_seg_nxt;

      if (w_copy)        r_pending <= 1'b0;
      else if (w_accept) r_pending <= 1'b1;

      if (w_copy) begin
        for (int i = 0; i < NDIG; i++) r_active[i] <= r_shadow[i];
      end

      if (wr_valid) r_shadow[wr_idx] <= '{on: wr_on, data: wr_data};
    end
  end

  assign commit_ready = !r_pending;
  assign commit_done  = r_done;
  assign an           = r_an;
  assign seg          = r_seg;

endmodule
